// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Pipeline-stage register carrying a DATA_W payload between two adjacent
//   pipeline stages with a valid/ready handshake and synchronous flush.
//   SKID_EN=1 adds a second (skid) entry so in_ready comes straight from a flop,
//   cutting the combinational stall path from downstream back to fetch.
//   SKID_EN=0 is a single entry with combinational in_ready.
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             kill all held entries (push in same cycle is dropped)
//   in_valid/in_ready/in_data     upstream handshake + payload
//   out_valid/out_ready/out_data  downstream handshake + payload (oldest entry)
//   occupancy         number of held entries (0..1+SKID_EN)
module pipe_stage_buf #(
  parameter int                DATA_W  = 96,
  parameter int                SKID_EN = 1,
  parameter logic [DATA_W-1:0] BUBBLE  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic push, pop;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_ONE   = 2'd1;
      localparam logic [1:0] ST_TWO   = 2'd2;

      logic [1:0]        state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              in_ready_q, in_ready_d;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (push) begin
                state_d = ST_ONE;
                main_d  = in_data;
              end
            end
            ST_ONE: begin
              if (push && pop) begin
                main_d = in_data;
              end else if (push) begin
                state_d = ST_TWO;
                skid_d  = in_data;
              end else if (pop) begin
                state_d = ST_EMPTY;
                main_d  = BUBBLE;
              end
            end
            ST_TWO: begin
              // in_ready is low here, so only a pop can move the state
              if (pop) begin
                state_d = ST_ONE;
                main_d  = skid_q;
                skid_d  = BUBBLE;
              end
            end
            default: begin
              state_d = ST_EMPTY;
              main_d  = BUBBLE;
              skid_d  = BUBBLE;
            end
          endcase
        end
        // Registered ready: look ahead at the next state so the flop is
        // already correct in the cycle the stage becomes full/non-full.
        in_ready_d = (state_d != ST_TWO);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= ST_EMPTY;
          main_q     <= BUBBLE;
          skid_q     <= BUBBLE;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != ST_EMPTY);
      assign out_data  = main_q;
      assign occupancy = state_q;  // encoding equals entry count

`ifndef SYNTHESIS
      a_full_not_ready: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_TWO) |-> !in_ready_q);
`endif
    end else begin : g_single
      logic              valid_q, valid_d;
      logic [DATA_W-1:0] main_q, main_d;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
          main_d  = BUBBLE;
        end else if (push) begin
          // push with or without pop: the new payload replaces the entry
          valid_d = 1'b1;
          main_d  = in_data;
        end else if (pop) begin
          valid_d = 1'b0;
          main_d  = BUBBLE;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          main_q  <= BUBBLE;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign out_data  = main_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

`ifndef SYNTHESIS
  a_occ_max: assert property (@(posedge clk) disable iff (rst)
    occupancy <= 2'(1 + SKID_EN));
  a_push_ready: assert property (@(posedge clk) disable iff (rst)
    push |-> in_ready);
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one skid instance (s_*) and one single-entry
// instance (n_*), each tracked by a FIFO scoreboard queue.
module tb_pipe_stage_buf;
  localparam int          DW  = 16;
  localparam logic [15:0] BUB = 16'hDEAD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_occ;
  logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [1:0]    n_occ;

  pipe_stage_buf #(.DATA_W(DW), .SKID_EN(1), .BUBBLE(BUB)) u_skid (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ));

  pipe_stage_buf #(.DATA_W(DW), .SKID_EN(0), .BUBBLE(BUB)) u_single (
    .clk(clk), .rst(rst), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occ));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Scoreboard update on each edge using pre-edge handshake values.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (s_out_valid && s_out_ready) begin
        if (q0.size() == 0) chk("s_pop_empty", 1, 0);
        else chk("s_pop_data", s_out_data, q0.pop_front());
      end
      if (s_flush) q0.delete();
      else if (s_in_valid && s_in_ready) q0.push_back(s_in_data);
      if (n_out_valid && n_out_ready) begin
        if (q1.size() == 0) chk("n_pop_empty", 1, 0);
        else chk("n_pop_data", n_out_data, q1.pop_front());
      end
      if (n_flush) q1.delete();
      else if (n_in_valid && n_in_ready) q1.push_back(n_in_data);
    end
  end

  // Mid-cycle state checks against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("s_occ", 32'(s_occ), q0.size());
      chk("s_out_valid", 32'(s_out_valid), 32'(q0.size() != 0));
      chk("s_out_data", 32'(s_out_data), 32'(q0.size() != 0 ? q0[0] : BUB));
      chk("s_in_ready", 32'(s_in_ready), 32'(q0.size() != 2));
      chk("n_occ", 32'(n_occ), q1.size());
      chk("n_out_valid", 32'(n_out_valid), 32'(q1.size() != 0));
      chk("n_out_data", 32'(n_out_data), 32'(q1.size() != 0 ? q1[0] : BUB));
      chk("n_in_ready", 32'(n_in_ready), 32'(q1.size() == 0 || n_out_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] d;

  initial begin
    rst = 1'b1;
    s_flush = 0; s_in_valid = 1; s_in_data = 16'h00A5; s_out_ready = 0;
    n_flush = 0; n_in_valid = 1; n_in_data = 16'h00A5; n_out_ready = 0;
    tick(); tick();
    // 1: reset
    chk("rst_s_out_valid", 32'(s_out_valid), 0);
    chk("rst_s_out_data", 32'(s_out_data), 32'(BUB));
    chk("rst_s_occ", 32'(s_occ), 0);
    chk("rst_s_in_ready", 32'(s_in_ready), 1);
    chk("rst_n_out_valid", 32'(n_out_valid), 0);
    chk("rst_n_out_data", 32'(n_out_data), 32'(BUB));
    chk("rst_n_occ", 32'(n_occ), 0);
    chk("rst_n_in_ready", 32'(n_in_ready), 1);
    rst = 0; s_in_valid = 0; n_in_valid = 0; s_out_ready = 1; n_out_ready = 1;
    tick();

    // 2: streaming, 1-cycle latency, occupancy 1
    for (int i = 0; i < 3; i++) begin
      d = 16'h0100 + 16'(4 * i);
      s_in_valid = 1; s_in_data = d; n_in_valid = 1; n_in_data = d;
      tick();
      chk("str_s_data", 32'(s_out_data), 32'(d));
      chk("str_s_occ", 32'(s_occ), 1);
      chk("str_n_data", 32'(n_out_data), 32'(d));
      chk("str_n_occ", 32'(n_occ), 1);
    end
    s_in_valid = 0; n_in_valid = 0;
    tick();
    chk("str_s_drain", 32'(s_occ), 0);
    chk("str_n_drain", 32'(n_occ), 0);

    // 3: skid fill then drain
    s_out_ready = 0; s_in_valid = 1; s_in_data = 16'h0010;
    tick();
    s_in_data = 16'h0014;
    tick();
    chk("skid_occ2", 32'(s_occ), 2);
    chk("skid_rdy0", 32'(s_in_ready), 0);
    chk("skid_head", 32'(s_out_data), 32'h10);
    s_in_valid = 0; s_out_ready = 1;
    tick();
    chk("skid_pop1", 32'(s_out_data), 32'h14);
    chk("skid_rdy1", 32'(s_in_ready), 1);
    tick();
    chk("skid_empty", 32'(s_occ), 0);

    // 4: flush while full with a push in the same cycle
    s_out_ready = 0; s_in_valid = 1; s_in_data = 16'h0040;
    tick();
    s_in_data = 16'h0044;
    tick();
    chk("fl_occ2", 32'(s_occ), 2);
    s_flush = 1; s_in_data = 16'h0020;
    tick();
    chk("fl_valid", 32'(s_out_valid), 0);
    chk("fl_occ", 32'(s_occ), 0);
    chk("fl_data", 32'(s_out_data), 32'(BUB));
    s_flush = 0; s_in_valid = 0; s_out_ready = 1;
    tick(); tick();
    chk("fl_no_0x20", 32'(s_out_valid), 0);

    // 5: single entry, combinational ready and replace
    n_out_ready = 0; n_in_valid = 1; n_in_data = 16'h0030;
    tick();
    n_in_valid = 0;
    chk("se_hold", 32'(n_out_data), 32'h30);
    chk("se_rdy0", 32'(n_in_ready), 0);
    n_out_ready = 1; n_in_valid = 1; n_in_data = 16'h0034;
    #1;
    chk("se_rdy_comb", 32'(n_in_ready), 1);
    tick();
    chk("se_replace", 32'(n_out_data), 32'h34);
    n_in_valid = 0;
    tick();
    chk("se_empty", 32'(n_occ), 0);

    // 6: random traffic against the scoreboards
    repeat (10000) begin
      s_in_valid  = ($urandom_range(0, 9) < 6);
      s_out_ready = ($urandom_range(0, 9) < 6);
      s_flush     = ($urandom_range(0, 49) == 0);
      s_in_data   = 16'($urandom);
      n_in_valid  = ($urandom_range(0, 9) < 6);
      n_out_ready = ($urandom_range(0, 9) < 6);
      n_flush     = ($urandom_range(0, 49) == 0);
      n_in_data   = 16'($urandom);
      tick();
    end
    s_in_valid = 0; s_flush = 0; s_out_ready = 1;
    n_in_valid = 0; n_flush = 0; n_out_ready = 1;
    tick(); tick(); tick();
    chk("rnd_s_drain", 32'(s_occ), 0);
    chk("rnd_n_drain", 32'(n_occ), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
